serial_add_ctrl: RTL

- Multi-cycle controller that performs a WIDTH-bit add or subtract by sequencing one instance of the 1-bit full-adder cell (Add1) bit-serially, LSB first.
- Serves as the area-minimal arithmetic path for low-cost core variants and for background tasks such as address stepping.
- Sits between an issuing unit (valid/ready request) and a consuming unit (valid/ready result).

---
 rtl/serial_add_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial WIDTH-bit adder/subtractor controller. A single 1-bit full-adder
// cell (the Add1 cell) is stepped across the operands, LSB first, one bit per
// clock. The unit is area-minimal rather than fast. It takes WIDTH clocks per
// operation plus one request and one result handshake cycle.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous, active-high reset
//   in_valid   in   request valid
//   in_ready   out  request can be accepted (IDLE only)
//   in_a       in   operand A            [WIDTH-1:0]
//   in_b       in   operand B            [WIDTH-1:0]
//   in_sub     in   1 = A - B, 0 = A + B
//   out_valid  out  result valid (DONE only)
//   out_ready  in   consumer accepts the result
//   out_sum    out  result, modulo 2^WIDTH [WIDTH-1:0]
//   out_carry  out  carry out of the MSB (for subtract: 1 = no borrow)
//   out_ovf    out  signed overflow        (SERIAL_ADD_FLAGS_EN only)
//   out_zero   out  result is zero         (SERIAL_ADD_FLAGS_EN only)
//
// Configuration macro: SERIAL_ADD_FLAGS_EN adds the out_ovf / out_zero flags
// and their logic. When it is undefined, neither the ports nor the logic exist.
// ---------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry
`ifdef SERIAL_ADD_FLAGS_EN
    ,
    output logic             out_ovf,
    output logic             out_zero
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic             carry_q, carry_d;
    // Only WIDTH-1 partial bits are kept. The final S bit goes straight into
    // the output register on the last step.
    logic [WIDTH-2:0] res_sr_q, res_sr_d;
    logic [WIDTH-1:0] sum_out_q, sum_out_d;
    logic             carry_out_q, carry_out_d;
`ifdef SERIAL_ADD_FLAGS_EN
    logic             any_one_q, any_one_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
`endif

    logic             fa_a, fa_b, fa_i, fa_s, fa_o;
    logic [WIDTH-1:0] shifted;

    // The Add1 full-adder cell, fed from the shift-register LSBs and the carry.
    always_comb begin
        fa_a    = a_sr_q[0];
        fa_b    = b_sr_q[0];
        fa_i    = carry_q;
        fa_s    = fa_a ^ fa_b ^ fa_i;
        fa_o    = (fa_a & fa_b) | (fa_a & fa_i) | (fa_b & fa_i);
        shifted = {fa_s, res_sr_q};
    end

    // Next-state logic.
    // Subtract is A + ~B + 1: B is inverted on load and the carry is seeded
    // with in_sub.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        carry_d     = carry_q;
        res_sr_d    = res_sr_q;
        sum_out_d   = sum_out_q;
        carry_out_d = carry_out_q;
`ifdef SERIAL_ADD_FLAGS_EN
        any_one_d   = any_one_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sr_d    = in_a;
                    b_sr_d    = in_b ^ {WIDTH{in_sub}};
                    carry_d   = in_sub;
                    cnt_d     = '0;
                    state_d   = ST_RUN;
`ifdef SERIAL_ADD_FLAGS_EN
                    any_one_d = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                carry_d  = fa_o;
                res_sr_d = shifted[WIDTH-1:1];
                cnt_d    = cnt_q + CW'(1);
`ifdef SERIAL_ADD_FLAGS_EN
                any_one_d = any_one_q | fa_s;
`endif
                // MSB step: publish the result. fa_i here is the carry into the MSB.
                if (cnt_q == LAST_BIT) begin
                    state_d     = ST_DONE;
                    sum_out_d   = shifted;
                    carry_out_d = fa_o;
`ifdef SERIAL_ADD_FLAGS_EN
                    ovf_d       = fa_i ^ fa_o;
                    zero_d      = ~(any_one_q | fa_s);
`endif
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset. Reset abandons any operation
    // in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            carry_q     <= 1'b0;
            res_sr_q    <= '0;
            sum_out_q   <= '0;
            carry_out_q <= 1'b0;
`ifdef SERIAL_ADD_FLAGS_EN
            any_one_q   <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            carry_q     <= carry_d;
            res_sr_q    <= res_sr_d;
            sum_out_q   <= sum_out_d;
            carry_out_q <= carry_out_d;
`ifdef SERIAL_ADD_FLAGS_EN
            any_one_q   <= any_one_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_sum   = sum_out_q;
    assign out_carry = carry_out_q;
`ifdef SERIAL_ADD_FLAGS_EN
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;
`endif

endmodule
